// File: rtl/jk_latch_driver.sv
// jk_latch_driver: command-side controller for a bank of level-sensitive JK
// latch cells. Converts target/toggle requests into per-bit J/K excitation,
// pulses the shared enable, reads back and retries on mismatch.
module jk_latch_driver #(
    parameter int WIDTH     = 8,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_toggle,
    input  logic [WIDTH-1:0] req_data,
    input  logic             clr_req,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             latch_en,
    output logic             latch_rst,
    input  logic [WIDTH-1:0] q,
    output logic             done,
    output logic             err,
    output logic [1:0]       retries
);

    typedef enum logic [2:0] {IDLE, DRIVE, RELEASE, CLEAR, CHECK} state_t;

    localparam int            CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CLAST = CW'(SETTLE - 1);
    localparam logic [7:0]    MAXR  = 8'(MAX_RETRY);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [7:0]       rcnt, rcnt_nx;
    logic [WIDTH-1:0] target, target_nx;
    logic [WIDTH-1:0] j_nx, k_nx;
    logic             en_nx, lrst_r, lrst_nx, done_nx, err_nx;
    logic [1:0]       retries_nx;

    // Bank reset follows controller reset combinationally so both clear together.
    assign latch_rst = reset | lrst_r;
    assign req_ready = (state == IDLE) & ~reset & ~clr_req;

    // Next-state and next-output decode; registered outputs keep their value by default.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rcnt_nx    = rcnt;
        target_nx  = target;
        j_nx       = j;
        k_nx       = k;
        en_nx      = latch_en;
        lrst_nx    = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        retries_nx = retries;
        case (state)
            IDLE: begin
                j_nx  = '0;
                k_nx  = '0;
                en_nx = 1'b0;
                if (clr_req) begin
                    state_nx  = CLEAR;
                    target_nx = '0;
                    rcnt_nx   = '0;
                    lrst_nx   = 1'b1;
                end else if (req_valid) begin
                    target_nx = req_toggle ? (q ^ req_data) : req_data;
                    rcnt_nx   = '0;
                    cnt_nx    = '0;
                    // Only bits that differ are excited; J and K are never both high.
                    j_nx      = target_nx & ~q;
                    k_nx      = ~target_nx & q;
                    en_nx     = 1'b1;
                    state_nx  = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == CLAST) begin
                    state_nx = RELEASE;
                    en_nx    = 1'b0;
                    j_nx     = '0;
                    k_nx     = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RELEASE: state_nx = CHECK;
            CLEAR:   state_nx = CHECK;
            CHECK: begin
                if (q == target) begin
                    done_nx    = 1'b1;
                    retries_nx = (rcnt > 8'd3) ? 2'd3 : rcnt[1:0];
                    state_nx   = IDLE;
                end else if (rcnt < MAXR) begin
                    // Re-drive from the fresh readback; also covers a failed clear.
                    rcnt_nx  = rcnt + 8'd1;
                    cnt_nx   = '0;
                    j_nx     = target & ~q;
                    k_nx     = ~target & q;
                    en_nx    = 1'b1;
                    state_nx = DRIVE;
                end else begin
                    err_nx     = 1'b1;
                    retries_nx = (rcnt > 8'd3) ? 2'd3 : rcnt[1:0];
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and registered outputs; reset abandons any partial write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rcnt     <= '0;
            target   <= '0;
            j        <= '0;
            k        <= '0;
            latch_en <= 1'b0;
            lrst_r   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            retries  <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rcnt     <= rcnt_nx;
            target   <= target_nx;
            j        <= j_nx;
            k        <= k_nx;
            latch_en <= en_nx;
            lrst_r   <= lrst_nx;
            done     <= done_nx;
            err      <= err_nx;
            retries  <= retries_nx;
        end
    end

endmodule

// File: tb/tb_jk_latch_driver.sv
// Bench for jk_latch_driver: behavioural JK latch bank plus per-feature tests
// and a randomized request stream checked against a target-level model.
module tb_jk_latch_driver;

    localparam int W      = 8;
    localparam int SETTLE = 2;
    localparam int MAXR   = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_toggle = 1'b0;
    logic [W-1:0] req_data = '0;
    logic         clr_req = 1'b0;
    logic [W-1:0] j, k, q;
    logic         latch_en, latch_rst, done, err;
    logic [1:0]   retries;

    logic [W-1:0] bq = '0;     // bank storage
    logic [W-1:0] stuck = '0;  // bits held at 0 by a faulty cell

    int n_checks = 0;
    int n_fail   = 0;

    jk_latch_driver #(.WIDTH(W), .SETTLE(SETTLE), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_toggle(req_toggle), .req_data(req_data), .clr_req(clr_req),
        .j(j), .k(k), .latch_en(latch_en), .latch_rst(latch_rst), .q(q),
        .done(done), .err(err), .retries(retries)
    );

    always #5 clk = ~clk;

    // Latch bank: J sets, K clears while enabled; reset clears everything.
    assign q = bq & ~stuck;
    always @(posedge clk) begin
        if (latch_rst)     bq <= '0;
        else if (latch_en) bq <= (q | j) & ~k;
    end

    // Issue one request and watch it through to done/err (no checking here).
    task automatic run_req(input logic tog, input logic [W-1:0] d, output int lat,
                           output logic gd, output logic ge, output logic [W-1:0] js,
                           output logic [W-1:0] ks, output int enc, output logic jk_bad);
        int w;
        w = 0;
        while (!req_ready && w < 200) begin @(posedge clk); #1; w++; end
        req_valid = 1'b1; req_toggle = tog; req_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; enc = 0; jk_bad = 1'b0; js = '0; ks = '0;
        while (!(done || err) && lat < 200) begin
            if (latch_en) begin
                if (enc == 0) begin js = j; ks = k; end
                enc++;
            end
            if ((j & k) != '0) jk_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        gd = done; ge = err;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({j, k, latch_en, done, err, retries} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got j=%h k=%h en=%b done=%b err=%b r=%0d, want all 0",
                               j, k, latch_en, done, err, retries);
        end
        n_checks++;
        if (latch_rst !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rst_ready: got rst=%b ready=%b, want 1/0", latch_rst, req_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (latch_rst !== 1'b0 || req_ready !== 1'b1 || q !== '0) begin
            n_fail++; $display("FAIL reset_release: got rst=%b ready=%b q=%h, want 0/1/00", latch_rst, req_ready, q);
        end
    endtask

    task automatic test_load();
        int lat, enc; logic gd, ge, bad; logic [W-1:0] js, ks;
        run_req(1'b0, 8'hA5, lat, gd, ge, js, ks, enc, bad);
        n_checks++;
        if (js !== 8'hA5 || ks !== 8'h00) begin
            n_fail++; $display("FAIL load_jk: got j=%h k=%h, want A5/00", js, ks);
        end
        n_checks++;
        if (enc !== SETTLE || lat !== SETTLE + 2 || gd !== 1'b1 || ge !== 1'b0) begin
            n_fail++; $display("FAIL load_timing: got en=%0d lat=%0d done=%b err=%b, want %0d/%0d/1/0",
                               enc, lat, gd, ge, SETTLE, SETTLE + 2);
        end
        n_checks++;
        if (q !== 8'hA5 || retries !== 2'd0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_result: got q=%h r=%0d ready=%b, want A5/0/1", q, retries, req_ready);
        end
    endtask

    task automatic test_min_excitation();
        int lat, enc; logic gd, ge, bad; logic [W-1:0] js, ks;
        run_req(1'b0, 8'hF0, lat, gd, ge, js, ks, enc, bad);
        run_req(1'b0, 8'h3C, lat, gd, ge, js, ks, enc, bad);
        n_checks++;
        if (js !== 8'h0C || ks !== 8'hC0 || bad !== 1'b0) begin
            n_fail++; $display("FAIL min_exc: got j=%h k=%h jk_both=%b, want 0C/C0/0", js, ks, bad);
        end
        n_checks++;
        if (gd !== 1'b1 || q !== 8'h3C) begin
            n_fail++; $display("FAIL min_exc_done: got done=%b q=%h, want 1/3C", gd, q);
        end
    endtask

    task automatic test_toggle();
        int lat, enc; logic gd, ge, bad; logic [W-1:0] js, ks;
        run_req(1'b0, 8'h55, lat, gd, ge, js, ks, enc, bad);
        run_req(1'b1, 8'h0F, lat, gd, ge, js, ks, enc, bad);
        n_checks++;
        if (js !== 8'h0A || ks !== 8'h05) begin
            n_fail++; $display("FAIL toggle_jk: got j=%h k=%h, want 0A/05", js, ks);
        end
        n_checks++;
        if (gd !== 1'b1 || q !== 8'h5A || lat !== SETTLE + 2) begin
            n_fail++; $display("FAIL toggle_done: got done=%b q=%h lat=%0d, want 1/5A/%0d", gd, q, lat, SETTLE + 2);
        end
    endtask

    task automatic test_stuck();
        int lat, enc; logic gd, ge, bad; logic [W-1:0] js, ks;
        run_req(1'b0, 8'h00, lat, gd, ge, js, ks, enc, bad);
        stuck = 8'h01;
        run_req(1'b0, 8'h01, lat, gd, ge, js, ks, enc, bad);
        n_checks++;
        if (ge !== 1'b1 || gd !== 1'b0 || lat !== (1 + MAXR) * (SETTLE + 2)) begin
            n_fail++; $display("FAIL stuck_err: got err=%b done=%b lat=%0d, want 1/0/%0d",
                               ge, gd, lat, (1 + MAXR) * (SETTLE + 2));
        end
        n_checks++;
        if (retries !== 2'd3 || enc !== (1 + MAXR) * SETTLE) begin
            n_fail++; $display("FAIL stuck_retries: got r=%0d en=%0d, want 3/%0d", retries, enc, (1 + MAXR) * SETTLE);
        end
        stuck = '0;
    endtask

    task automatic test_clear_priority();
        int lat, enc; logic gd, ge, bad; logic [W-1:0] js, ks;
        run_req(1'b0, 8'hFF, lat, gd, ge, js, ks, enc, bad);
        clr_req = 1'b1; req_valid = 1'b1; req_toggle = 1'b0; req_data = 8'h3C;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL clr_ready: got ready=%b, want 0", req_ready);
        end
        @(posedge clk); #1;
        clr_req = 1'b0;
        n_checks++;
        if (latch_rst !== 1'b1 || latch_en !== 1'b0) begin
            n_fail++; $display("FAIL clr_pulse: got rst=%b en=%b, want 1/0", latch_rst, latch_en);
        end
        lat = 0;
        while (!(done || err) && lat < 50) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (done !== 1'b1 || lat !== 2 || q !== 8'h00 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL clr_done: got done=%b lat=%0d q=%h ready=%b, want 1/2/00/1",
                               done, lat, q, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (latch_en !== 1'b1 || j !== 8'h3C) begin
            n_fail++; $display("FAIL clr_then_req: got en=%b j=%h, want 1/3C", latch_en, j);
        end
        lat = 0;
        while (!(done || err) && lat < 50) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (done !== 1'b1 || q !== 8'h3C) begin
            n_fail++; $display("FAIL clr_then_req_done: got done=%b q=%h, want 1/3C", done, q);
        end
    endtask

    task automatic test_reset_mid_drive();
        int seen;
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_toggle = 1'b0; req_data = 8'hC3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (latch_rst !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_comb: got rst=%b ready=%b, want 1/0", latch_rst, req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (latch_en !== 1'b0 || j !== '0 || k !== '0) begin
            n_fail++; $display("FAIL rstmid_drop: got en=%b j=%h k=%h, want 0/00/00", latch_en, j, k);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || q !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_ready: got ready=%b q=%h, want 1/00", req_ready, q);
        end
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (done || err) seen++; end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL rstmid_nopulse: got %0d done/err pulses, want 0", seen);
        end
    endtask

    // Random requests back to back, with occasional faulty cells.
    task automatic test_random();
        int lat, enc, exp_lat, exp_enc; logic gd, ge, bad, ok;
        logic [W-1:0] js, ks, d, q0, tgt;
        logic tog;
        for (int n = 0; n < 30; n++) begin
            tog   = 1'($urandom_range(1, 0));
            d     = W'($urandom);
            stuck = ($urandom_range(3, 0) == 0) ? W'(1 << $urandom_range(W - 1, 0)) : '0;
            #0;
            q0  = q;
            tgt = tog ? (q0 ^ d) : d;
            ok  = (tgt & stuck) == '0;
            exp_lat = ok ? (SETTLE + 2) : (1 + MAXR) * (SETTLE + 2);
            exp_enc = ok ? SETTLE : (1 + MAXR) * SETTLE;
            run_req(tog, d, lat, gd, ge, js, ks, enc, bad);
            n_checks++;
            if (js !== (tgt & ~q0) || ks !== (~tgt & q0) || bad !== 1'b0) begin
                n_fail++; $display("FAIL rand_jk[%0d]: got j=%h k=%h both=%b, want %h/%h/0",
                                   n, js, ks, bad, tgt & ~q0, ~tgt & q0);
            end
            n_checks++;
            if (gd !== ok || ge !== !ok || lat !== exp_lat || enc !== exp_enc) begin
                n_fail++; $display("FAIL rand_outcome[%0d]: got done=%b err=%b lat=%0d en=%0d, want %b/%b/%0d/%0d",
                                   n, gd, ge, lat, enc, ok, !ok, exp_lat, exp_enc);
            end
            n_checks++;
            if (q !== (tgt & ~stuck) || retries !== (ok ? 2'd0 : 2'd3)) begin
                n_fail++; $display("FAIL rand_result[%0d]: got q=%h r=%0d, want %h/%0d",
                                   n, q, retries, tgt & ~stuck, ok ? 0 : 3);
            end
        end
        stuck = '0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_min_excitation();
        test_toggle();
        test_stuck();
        test_clear_priority();
        test_reset_mid_drive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_latch_driver.md
# jk_latch_driver

Command-side controller for a bank of WIDTH level-sensitive JK latch cells. It accepts target-value or toggle-mask requests over a valid/ready handshake and converts them into per-bit J/K excitation. It pulses the shared enable, reads the latch outputs back and retries on mismatch. It sits between the register-control logic and the JK latch bank, and is the only block that drives the bank's J, K, enable and reset inputs.

## Interface
- WIDTH, 8, number of latch cells driven.
- SETTLE, 2, cycles latch_en is held high per drive attempt (≥1).
- MAX_RETRY, 3, re-drive attempts after the first before flagging error (≥0).

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_toggle  in  1  0: req_data is absolute target; 1: req_data is toggle mask.
- req_data  in  WIDTH  target value or toggle mask.
- clr_req  in  1  request to clear the whole bank; sampled only when idle.
- j  out  WIDTH  J excitation to latch bank.
- k  out  WIDTH  K excitation to latch bank.
- latch_en  out  1  level enable to latch bank.
- latch_rst  out  1  reset to latch bank.
- q  in  WIDTH  latch bank readback.
- done  out  1  one-cycle pulse: readback matched target.
- err  out  1  one-cycle pulse: mismatch after MAX_RETRY retries.
- retries  out  2  retry count of the last completed operation; saturates at 3.

## Operation
- States: IDLE, DRIVE, RELEASE, CLEAR, CHECK.
- IDLE: req_ready=1, j=k=0, latch_en=0.
  - clr_req=1: go to CLEAR. clr_req has priority over req_valid, and req_ready drops to 0 that cycle.
  - req_valid=1 with clr_req=0: accept and capture the target. Target = req_data when req_toggle=0, or q ^ req_data when req_toggle=1, using q sampled at the accept edge. Clear the retry counter and go to DRIVE.
- Excitation is computed from the registered target and q registered on DRIVE entry, per bit:
  - q==target: J=0, K=0.
  - target=1: J=1, K=0.
  - target=0: J=0, K=1.
  - J=K=1 is never driven. A level latch with enable high would oscillate on it.
- DRIVE: latch_en=1 with j/k as above for exactly SETTLE cycles, then go to RELEASE.
- RELEASE: latch_en=0, j=k=0 for one cycle, then go to CHECK.
- CLEAR: latch_rst=1 for one cycle; target is set to 0. Then go to CHECK.
- CHECK: compare q with target.
  - Match: done=1 next cycle, return to IDLE.
  - Mismatch with retry count < MAX_RETRY: increment count, go to DRIVE (excitation recomputed from fresh q).
  - Mismatch with retry count = MAX_RETRY: err=1 next cycle, return to IDLE.
  - A failed CLEAR is retried through DRIVE with target 0.
- retries updates on the done/err cycle.
- reset: next state IDLE; j=k=0, latch_en=0, done=err=0, retries=0, target=0.
  - latch_rst is asserted combinationally while reset=1, so the bank clears together with the controller.
  - req_ready=0 while reset=1.
  - Reset mid-DRIVE drops latch_en at the next edge. A partial write is not completed.

## Timing
- Accept edge E0 (req_valid & req_ready).
- DRIVE occupies edges E0+1..E0+SETTLE, RELEASE E0+SETTLE+1, CHECK E0+SETTLE+2.
- done/err high in the cycle following CHECK, concurrent with req_ready=1. For SETTLE=2, done is visible 4 cycles after accept.
- Each retry adds SETTLE+2 cycles.
- Clear path: latch_rst high in cycle E0+1, CHECK at E0+2, done at E0+3.
- A new request can be accepted in the same cycle done/err is high.
- Outputs j, k, latch_en, done, err are registered. Only latch_rst has a combinational term (from reset).

## Test plan
- Reset then load: q=8'h00, req_data=8'hA5, toggle=0 -> j=8'hA5, k=8'h00, latch_en high 2 cycles. Model latch follows, done at accept+4, retries=0.
- Minimal excitation: q=8'hF0, target 8'h3C -> j=8'h0C, k=8'hC0, never any bit with j&k=1.
- Toggle mode: q=8'h55, req_data=8'h0F, toggle=1 -> target 8'h5A, j=8'h0A, k=8'h05, done with q=8'h5A.
- Stuck bit: model holds bit0 at 0, target 8'h01 -> 4 drive attempts (1+MAX_RETRY), err at accept+16, retries=3, no done.
- Clear priority: clr_req=1 and req_valid=1 together in IDLE with q=8'hFF -> latch_rst pulse, request not accepted, done after clear with q=8'h00. The request is accepted on the next idle cycle.
- Reset mid-DRIVE: assert reset on the second DRIVE cycle -> next edge latch_en=0, j=k=0. latch_rst=1 during reset, req_ready=1 the cycle after reset drops, no done/err pulse.
